mimasuo_code_sender: RTL and testbench

- Transmit-side counterpart of the combination-lock logic: plays a stored code word into the lock as a timed sequence of button0/button1 presses.
- After the last press, watches UNLOCK for a bounded window and reports pass/fail.
- Sits between a host or self-test controller and the lock's button inputs.
- Used for automated lock bring-up and for regression against the lock's code-matching FSM.

---
 rtl/mimasuo_pkg.sv | 9 +
 rtl/mimasuo_tick_counter.sv | 18 +
 rtl/mimasuo_code_sender.sv | 98 +++++++++
 tb/tb_mimasuo_code_sender.sv | 176 +++++++++++++++++
 4 files changed

// File: rtl/mimasuo_pkg.sv
// mimasuo_pkg: shared state encoding, symbol values and helpers for the code sender
package mimasuo_pkg;
   typedef enum logic [2:0] {IDLE, PRESS, GAP, WAIT, DONE} state_t;
   localparam logic SYM_B0 = 1'b0;
   localparam logic SYM_B1 = 1'b1;
   function automatic int max3(input int a, input int b, input int c);
      return (a > b) ? ((a > c) ? a : c) : ((b > c) ? b : c);
   endfunction
endpackage

// File: rtl/mimasuo_tick_counter.sv
// mimasuo_tick_counter: loadable down-counter that stops at zero and flags it
module mimasuo_tick_counter #(
   parameter int W = 4
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         load,
   input  logic [W-1:0] value,
   output logic         zero
);
   logic [W-1:0] cnt;
   always_ff @(posedge clk) begin
      if (rst) cnt <= '0;
      else if (load) cnt <= value;
      else if (cnt != '0) cnt <= cnt - W'(1);
   end
   assign zero = (cnt == '0);
endmodule

// File: rtl/mimasuo_code_sender.sv
// mimasuo_code_sender: plays a stored code word into a combination lock as timed
// button presses, then watches unlock for a bounded window and reports pass/fail.
module mimasuo_code_sender
   import mimasuo_pkg::*;
#(
   parameter int CODE_LEN     = 8,
   parameter int PRESS_CYCLES = 2,
   parameter int GAP_CYCLES   = 1,
   parameter int TIMEOUT      = 16
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                start,
   input  logic [CODE_LEN-1:0] code,
   input  logic                abort,
   input  logic                unlock,
   output logic                button0,
   output logic                button1,
   output logic                busy,
   output logic                done,
   output logic                pass
);
   localparam int TW = $clog2(max3(PRESS_CYCLES, GAP_CYCLES, TIMEOUT) + 1);
   localparam int SW = $clog2(CODE_LEN) + 1;
   state_t state, nxt;
   logic [CODE_LEN-1:0] shreg, nxt_shreg;
   logic [SW-1:0] sym, nxt_sym;
   logic [TW-1:0] load_val;
   logic load, zero, nxt_pass;
   mimasuo_tick_counter #(.W(TW)) u_tick (
      .clk  (clk),
      .rst  (rst),
      .load (load),
      .value(load_val),
      .zero (zero)
   );
   // the one tick counter is reloaded on every state entry, so it never wraps
   always_comb begin
      nxt = state;
      nxt_shreg = shreg;
      nxt_sym = sym;
      nxt_pass = pass;
      load = 1'b0;
      load_val = '0;
      case (state)
         IDLE: if (start && !abort) begin
            nxt = PRESS;
            nxt_shreg = code;
            nxt_sym = SW'(CODE_LEN - 1);
            nxt_pass = 1'b0;
            load = 1'b1;
            load_val = TW'(PRESS_CYCLES - 1);
         end
         PRESS: if (zero) begin
            nxt = GAP;
            load = 1'b1;
            load_val = TW'(GAP_CYCLES - 1);
         end
         GAP: if (zero) begin
            nxt = (sym == '0) ? WAIT : PRESS;
            nxt_shreg = (sym == '0) ? shreg : shreg << 1;
            nxt_sym = (sym == '0) ? sym : sym - SW'(1);
            load = 1'b1;
            load_val = (sym == '0) ? TW'(TIMEOUT - 1) : TW'(PRESS_CYCLES - 1);
         end
         WAIT: if (unlock || zero) begin
            nxt = DONE;
            nxt_pass = unlock;
         end
         DONE: nxt = IDLE;
         default: nxt = IDLE;
      endcase
      if (abort && state != IDLE) begin
         nxt = IDLE;
         nxt_pass = 1'b0;
      end
   end
   // buttons are registered from the next state so they rise one cycle after start
   always_ff @(posedge clk) begin
      if (rst) begin
         state <= IDLE;
         shreg <= '0;
         sym <= '0;
         pass <= 1'b0;
         button0 <= 1'b0;
         button1 <= 1'b0;
      end else begin
         state <= nxt;
         shreg <= nxt_shreg;
         sym <= nxt_sym;
         pass <= nxt_pass;
         button0 <= (nxt == PRESS) && (nxt_shreg[CODE_LEN-1] == SYM_B0);
         button1 <= (nxt == PRESS) && (nxt_shreg[CODE_LEN-1] == SYM_B1);
      end
   end
   assign busy = (state == PRESS) || (state == GAP) || (state == WAIT);
   assign done = (state == DONE);
endmodule

// File: tb/tb_mimasuo_code_sender.sv
// tb_mimasuo_code_sender: directed vectors against a cycle-position model of the sender
module tb_mimasuo_code_sender;
   localparam int N = 4, P = 2, G = 1, TO = 8, S = N * (P + G);
   logic clk = 1'b0, rst = 1'b1, start = 1'b0, abort = 1'b0, unlock = 1'b0;
   logic [N-1:0] code = '0;
   logic button0, button1, busy, done, pass;
   int vectors = 0, miscompares = 0;

   mimasuo_code_sender #(.CODE_LEN(N), .PRESS_CYCLES(P), .GAP_CYCLES(G), .TIMEOUT(TO)) dut (
      .clk(clk), .rst(rst), .start(start), .code(code), .abort(abort), .unlock(unlock),
      .button0(button0), .button1(button1), .busy(busy), .done(done), .pass(pass)
   );

   always #5 clk = ~clk;

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
      end
   endtask

   // model: t counts cycles since the start was accepted; press/gap/wait follow from t
   logic m_active = 1'b0, m_done = 1'b0, m_pass = 1'b0;
   int t = 0;
   logic [N-1:0] m_code = '0;
   always @(negedge clk) begin
      logic e_b0, e_b1;
      e_b0 = 1'b0;
      e_b1 = 1'b0;
      if (m_active && t <= S && ((t - 1) % (P + G)) < P) begin
         e_b1 = m_code[N - 1 - (t - 1) / (P + G)];
         e_b0 = !e_b1;
      end
      chk("button0", 64'(button0), 64'(e_b0));
      chk("button1", 64'(button1), 64'(e_b1));
      chk("busy", 64'(busy), 64'(m_active));
      chk("done", 64'(done), 64'(m_done));
      chk("pass", 64'(pass), 64'(m_pass));
      if (rst) begin
         m_active = 1'b0; m_done = 1'b0; m_pass = 1'b0; t = 0;
      end else if (m_done) begin
         m_done = 1'b0;
         if (abort) m_pass = 1'b0;
      end else if (m_active) begin
         if (abort) begin
            m_active = 1'b0; m_pass = 1'b0;
         end else if (t > S && unlock) begin
            m_active = 1'b0; m_done = 1'b1; m_pass = 1'b1;
         end else if (t - S == TO) begin
            m_active = 1'b0; m_done = 1'b1; m_pass = 1'b0;
         end else t++;
      end else if (start && !abort) begin
         m_active = 1'b1; t = 1; m_code = code; m_pass = 1'b0;
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   function automatic logic [40:1] pairs(input int a, input int b, input int c, input int d);
      logic [40:1] m;
      m = '0;
      for (int i = 0; i < 4; i++) begin
         int s;
         s = (i == 0) ? a : (i == 1) ? b : (i == 2) ? c : d;
         if (s > 0) begin
            m[s] = 1'b1;
            m[s+1] = 1'b1;
         end
      end
      return m;
   endfunction

   // start sampled at the end of cycle 0; events given as cycle numbers (0 = none)
   task automatic run_seq(input logic [N-1:0] c_in, input int ulo, input int uhi, input int scyc,
                          input int acyc, input int rcyc, output int dcyc, output logic pv,
                          output logic [40:1] t1, output logic [40:1] t0);
      dcyc = 0; pv = 1'b0; t1 = '0; t0 = '0;
      tick();
      code = c_in;
      start = 1'b1;
      tick();
      for (int c = 1; c <= 40; c++) begin
         t1[c] = button1;
         t0[c] = button0;
         if (done) begin
            dcyc = c;
            pv = pass;
            break;
         end
         start = (c == scyc);
         abort = (c == acyc);
         rst = (c == rcyc);
         unlock = (c >= ulo) && (c <= uhi);
         tick();
      end
      start = 1'b0; abort = 1'b0; rst = 1'b0; unlock = 1'b0;
   endtask

   int dc;
   logic pv;
   logic [40:1] t1, t0;
   initial begin
      tick();
      tick();
      rst = 1'b0;
      chk("reset_outputs", 64'({button0, button1, busy, done, pass}), 64'd0);
      repeat (10) tick();
      chk("idle_outputs", 64'({button0, button1, busy, done, pass}), 64'd0);

      run_seq(4'b1010, 0, -1, 0, 0, 0, dc, pv, t1, t0);
      chk("timeout_done_cycle", 64'(dc), 64'd21);
      chk("timeout_pass", 64'(pv), 64'd0);
      chk("timeout_b1_trace", 64'(t1), 64'(pairs(1, 7, 0, 0)));
      chk("timeout_b0_trace", 64'(t0), 64'(pairs(4, 10, 0, 0)));

      run_seq(4'b1010, 15, 15, 0, 0, 0, dc, pv, t1, t0);
      chk("unlock_done_cycle", 64'(dc), 64'd16);
      chk("unlock_pass", 64'(pv), 64'd1);
      repeat (3) tick();
      chk("pass_held", 64'(pass), 64'd1);

      run_seq(4'b0111, 13, 13, 0, 0, 0, dc, pv, t1, t0);
      chk("first_wait_done_cycle", 64'(dc), 64'd14);
      chk("first_wait_pass", 64'(pv), 64'd1);
      chk("first_wait_b1_trace", 64'(t1), 64'(pairs(4, 7, 10, 0)));
      chk("first_wait_b0_trace", 64'(t0), 64'(pairs(1, 0, 0, 0)));

      run_seq(4'b1010, 0, -1, 8, 5, 0, dc, pv, t1, t0);
      chk("abort_restart_done_cycle", 64'(dc), 64'd29);
      chk("abort_restart_b1_trace", 64'(t1), 64'(pairs(1, 9, 15, 0)));
      chk("abort_restart_b0_trace", 64'(t0), 64'(pairs(4, 12, 18, 0)));

      run_seq(4'b1010, 0, -1, 3, 0, 0, dc, pv, t1, t0);
      chk("busy_start_done_cycle", 64'(dc), 64'd21);
      chk("busy_start_b1_trace", 64'(t1), 64'(pairs(1, 7, 0, 0)));
      chk("busy_start_b0_trace", 64'(t0), 64'(pairs(4, 10, 0, 0)));
      start = 1'b1;
      tick();
      chk("done_cycle_start_ignored", 64'({busy, button1}), 64'd0);
      tick();
      chk("next_cycle_start_taken", 64'({busy, button1}), 64'b11);
      start = 1'b0;
      dc = 0;
      for (int c = 0; c < 30 && dc == 0; c++) begin
         if (done) dc = 1;
         else tick();
      end
      chk("restart_reaches_done", 64'(dc), 64'd1);

      run_seq(4'b1010, 0, -1, 0, 0, 8, dc, pv, t1, t0);
      chk("rst_mid_no_done", 64'(dc), 64'd0);
      chk("rst_mid_b1_trace", 64'(t1), 64'(pairs(1, 7, 0, 0)));
      chk("rst_mid_b0_trace", 64'(t0), 64'(pairs(4, 0, 0, 0)));

      run_seq(4'b1010, 1, 12, 0, 0, 0, dc, pv, t1, t0);
      chk("press_unlock_done_cycle", 64'(dc), 64'd21);
      chk("press_unlock_pass", 64'(pv), 64'd0);

      tick();
      abort = 1'b1;
      start = 1'b1;
      tick();
      abort = 1'b0;
      start = 1'b0;
      chk("abort_beats_start", 64'(busy), 64'd0);
      repeat (2) tick();

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule
